// File: rtl/bus_poll_reader.sv
// Round-robin poller for four tri-state drivers sharing one bus.
// Each slot: break-before-make gap, settle, single capture, then hold.
module bus_poll_reader #(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned SLOT_MS = 1000,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              inclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] bus_data,
    output logic [3:0]        oe,
    output logic [1:0]        slot,
    output logic              sample_stb,
    output logic              changed,
    input  logic [1:0]        rd_slot,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam logic [31:0] K_LAST   = 32'(CLK_DIV * SLOT_MS) - 32'd1;
    localparam logic [31:0] K_SETTLE = 32'(SETTLE);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        DRIVE,
        SAMPLE,
        HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       k_q, k_d;
    logic [1:0]        slot_q, slot_d;
    logic              stb_q, stb_d;
    logic              chg_q, chg_d;
    logic [DATA_W-1:0] data_q [4];
    logic [DATA_W-1:0] data_d [4];
    logic [3:0]        valid_q, valid_d;

    always_ff @(posedge inclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            slot_q  <= '0;
            stb_q   <= 1'b0;
            chg_q   <= 1'b0;
            valid_q <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            slot_q  <= slot_d;
            stb_q   <= stb_d;
            chg_q   <= chg_d;
            valid_q <= valid_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        slot_d  = slot_q;
        stb_d   = 1'b0;
        chg_d   = 1'b0;
        valid_d = valid_q;
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
        end

        // Dropping en aborts the slot, including a capture about to land.
        if (!en) begin
            state_d = IDLE;
            k_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = GAP;
                    k_d     = '0;
                end
                GAP: begin
                    k_d     = 32'd1;
                    state_d = (K_SETTLE == '0) ? SAMPLE : DRIVE;
                end
                DRIVE: begin
                    k_d     = k_q + 32'd1;
                    state_d = (k_q == K_SETTLE) ? SAMPLE : DRIVE;
                end
                SAMPLE: begin
                    k_d             = k_q + 32'd1;
                    state_d         = HOLD;
                    stb_d           = 1'b1;
                    chg_d           = !valid_q[slot_q]
                                    || (data_q[slot_q] != bus_data);
                    data_d[slot_q]  = bus_data;
                    valid_d[slot_q] = 1'b1;
                end
                HOLD: begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = GAP;
                        slot_d  = slot_q + 2'd1;
                    end else begin
                        k_d = k_q + 32'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    // oe decodes from registered state only, so it is one-hot or zero.
    always_comb begin
        oe = 4'b0000;
        if (state_q == DRIVE || state_q == SAMPLE || state_q == HOLD) begin
            oe[slot_q] = 1'b1;
        end
    end

    assign slot       = slot_q;
    assign sample_stb = stb_q;
    assign changed    = chg_q;
    assign rd_data    = data_q[rd_slot];
    assign rd_valid   = valid_q[rd_slot];

endmodule

// File: tb/tb_bus_poll_reader.sv
// Self-checking bench for bus_poll_reader with a slot-position model.
module tb_bus_poll_reader;

    localparam int P      = 8;
    localparam int SETTLE = 2;

    logic       inclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [7:0] bus_data = 8'h00;
    logic [1:0] rd_slot = 2'd0;
    logic [3:0] oe;
    logic [1:0] slot;
    logic       sample_stb;
    logic       changed;
    logic [7:0] rd_data;
    logic       rd_valid;

    int total = 0;
    int bad = 0;

    bit         m_act;
    int         m_pos;
    int         m_slot;
    bit         m_stb;
    bit         m_chg;
    logic [7:0] m_data [4];
    bit         m_valid [4];

    bus_poll_reader #(
        .CLK_DIV(4),
        .SLOT_MS(2),
        .SETTLE (SETTLE),
        .DATA_W (8)
    ) dut (
        .inclk     (inclk),
        .rst_n     (rst_n),
        .en        (en),
        .bus_data  (bus_data),
        .oe        (oe),
        .slot      (slot),
        .sample_stb(sample_stb),
        .changed   (changed),
        .rd_slot   (rd_slot),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    always #5 inclk = ~inclk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: a slot is P cycles, position 0 is the dead gap and the
    // bus is read when position SETTLE+1 ends.
    task automatic model_step();
        if (!rst_n) begin
            m_act  = 0;
            m_pos  = 0;
            m_slot = 0;
            m_stb  = 0;
            m_chg  = 0;
            for (int i = 0; i < 4; i++) begin
                m_data[i]  = 8'h00;
                m_valid[i] = 0;
            end
        end else if (!en) begin
            m_act = 0;
            m_pos = 0;
            m_stb = 0;
            m_chg = 0;
        end else if (!m_act) begin
            m_act = 1;
            m_pos = 0;
            m_stb = 0;
            m_chg = 0;
        end else begin
            m_stb = 0;
            m_chg = 0;
            if (m_pos == SETTLE + 1) begin
                m_stb = 1;
                m_chg = !m_valid[m_slot] || (m_data[m_slot] != bus_data);
                m_data[m_slot]  = bus_data;
                m_valid[m_slot] = 1;
            end
            m_pos++;
            if (m_pos == P) begin
                m_pos  = 0;
                m_slot = (m_slot + 1) % 4;
            end
        end
    endtask

    function automatic logic [3:0] exp_oe();
        logic [3:0] v;
        v = 4'b0000;
        if (m_act && m_pos != 0) v = 4'(1 << m_slot);
        return v;
    endfunction

    // One cycle: model follows the edge, outputs compared mid-cycle.
    task automatic tick();
        @(posedge inclk);
        model_step();
        @(negedge inclk);
        chk("oe", 32'(oe), 32'(exp_oe()));
        chk("slot", 32'(slot), 32'(m_slot));
        chk("sample_stb", 32'(sample_stb), 32'(m_stb));
        chk("changed", 32'(changed), 32'(m_chg));
        chk("rd_data", 32'(rd_data), 32'(m_data[rd_slot]));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid[rd_slot]));
    endtask

    task automatic chk_rd_reset();
        for (int i = 0; i < 4; i++) begin
            rd_slot = 2'(i);
            #1;
            chk("rst_rd_data", 32'(rd_data), 32'h0);
            chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % P == 0) bus_data = 8'($urandom);
            tick();
        end
    endtask

    initial begin
        logic [7:0] old;

        tick();
        tick();
        chk("rst_oe", 32'(oe), 32'h0);
        chk("rst_slot", 32'(slot), 32'h0);
        chk("rst_stb", 32'(sample_stb), 32'h0);
        chk_rd_reset();

        rst_n = 1'b1;
        bus_data = 8'hA5;
        rd_slot = 2'd0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("s0_oe", 32'(oe), (c == 0) ? 32'h0 : 32'h1);
            chk("s0_stb", 32'(sample_stb), (c == 4) ? 32'h1 : 32'h0);
            chk("s0_chg", 32'(changed), (c == 4) ? 32'h1 : 32'h0);
        end
        chk("s0_rd", 32'(rd_data), 32'hA5);
        chk("s0_rv", 32'(rd_valid), 32'h1);

        for (int c = 0; c < 24; c++) begin
            if (c % 8 == 0) bus_data = 8'($urandom);
            tick();
            chk("seq_oe", 32'(oe),
                (c % 8 == 0) ? 32'h0 : 32'(1 << (1 + c / 8)));
            chk("seq_slot", 32'(slot), 32'(1 + c / 8));
        end

        bus_data = 8'hA5;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 0) chk("wrap_slot", 32'(slot), 32'h0);
            if (c == 4) begin
                chk("r2_stb", 32'(sample_stb), 32'h1);
                chk("r2_chg", 32'(changed), 32'h0);
            end
        end
        run(24);
        bus_data = 8'h3C;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 4) chk("r3_chg", 32'(changed), 32'h1);
        end
        rd_slot = 2'd0;
        #1;
        chk("r3_rd", 32'(rd_data), 32'h3C);

        run(8);
        run(6);
        en = 1'b0;
        tick();
        chk("dis_oe", 32'(oe), 32'h0);
        chk("dis_slot", 32'(slot), 32'h2);
        en = 1'b1;
        tick();
        chk("ren_gap", 32'(oe), 32'h0);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("ren_oe", 32'(oe), 32'h4);
        end

        run(4);
        old = m_data[3];
        bus_data = ~old;
        en = 1'b0;
        tick();
        chk("abort_stb", 32'(sample_stb), 32'h0);
        rd_slot = 2'd3;
        #1;
        chk("abort_data", 32'(rd_data), 32'(old));
        en = 1'b1;
        tick();
        run(5);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_oe", 32'(oe), 32'h0);
        chk("mid_rst_slot", 32'(slot), 32'h0);
        chk("mid_rst_stb", 32'(sample_stb), 32'h0);
        chk("mid_rst_chg", 32'(changed), 32'h0);
        chk_rd_reset();
        rst_n = 1'b1;
        tick();
        chk("resume_gap", 32'(oe), 32'h0);
        tick();
        chk("resume_oe", 32'(oe), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            en       = ($urandom_range(0, 24) != 0);
            bus_data = ($urandom_range(0, 2) == 0) ? 8'($urandom) : bus_data;
            rd_slot  = 2'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_poll_reader.md
BUS_POLL_READER -- requirements
Module: bus_poll_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000; inclk cycles per 1 ms.
REQ-002 SHALL have parameter SLOT_MS, default 1000; slot length in ms.
REQ-003 SHALL have parameter SETTLE, default 2; bus settle cycles after driver enable.
REQ-004 SHALL have parameter DATA_W, default 8; shared bus width.
REQ-005 SHALL have port inclk, input, 1 bit; the only clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit; synchronous active-low reset.
REQ-007 SHALL have port en, input, 1 bit; polling enable.
REQ-008 SHALL have port bus_data, input, DATA_W bits; resolved value of the shared tri-state bus.
REQ-009 SHALL have port oe, output, 4 bits; one-hot enable to the four tri-state drivers.
REQ-010 SHALL have port slot, output, 2 bits; index of the slot currently polled.
REQ-011 SHALL have port sample_stb, output, 1 bit; one-cycle pulse after each capture.
REQ-012 SHALL have port changed, output, 1 bit; one-cycle pulse, coincident with sample_stb, when the captured value differs from the stored value or the slot was not yet valid.
REQ-013 SHALL have port rd_slot, input, 2 bits; readback select.
REQ-014 SHALL have port rd_data, output, DATA_W bits; stored value of slot rd_slot.
REQ-015 SHALL have port rd_valid, output, 1 bit; slot rd_slot captured at least once since reset.

Function
REQ-016 SHALL define P = CLK_DIV*SLOT_MS cycles per slot; the slot cycle counter k SHALL be at least 32 bits wide; P >= SETTLE+3 is a legal-parameter precondition.
REQ-017 SHALL implement states IDLE, GAP, DRIVE, SAMPLE, HOLD; k runs 0..P-1 within each slot.
REQ-018 SHALL hold oe=0 in IDLE and in GAP (k=0); GAP is the break-before-make cycle.
REQ-019 SHALL drive oe = 1<<slot in DRIVE (k=1..SETTLE), SAMPLE (k=SETTLE+1) and HOLD (k=SETTLE+2..P-1).
REQ-020 SHALL, at the edge ending SAMPLE, write bus_data into data[slot] and set valid[slot].
REQ-021 SHALL assert sample_stb for exactly one cycle, the cycle at k=SETTLE+2.
REQ-022 SHALL assert changed in that same cycle only if the new value differed from the old data[slot] or valid[slot] was 0 before the write.
REQ-023 SHALL, at the edge ending k=P-1, increment slot modulo 4 (3 -> 0) and return k to 0 (GAP).
REQ-024 SHALL, with en=0 at any edge, enter IDLE at that edge, clear k, force oe=0, retain slot, data and valid; a capture pending in SAMPLE SHALL be discarded.
REQ-025 SHALL, with en=1 in IDLE, enter GAP of the retained slot at the next edge.
REQ-026 SHALL produce rd_data and rd_valid combinationally from data[rd_slot] and valid[rd_slot], with zero latency.
REQ-027 SHALL never assert more than one oe bit in any cycle, including across reset and en transitions.

Reset
REQ-028 SHALL, with rst_n=0 at a rising edge, set: state IDLE, k=0, oe=0, slot=0, sample_stb=0, changed=0, all data=0, all valid=0; rst_n SHALL take priority over en.
REQ-029 SHALL resume at GAP of slot 0 on the first edge with rst_n=1 and en=1, including after a reset asserted mid-slot.

Verification (CLK_DIV=4, SLOT_MS=2 -> P=8, SETTLE=2)
REQ-030 SHALL cover: rst_n=0 for 2 cycles, en=1 -> oe=0, slot=0, sample_stb=0, rd_valid=0, rd_data=0 for rd_slot 0..3.
REQ-031 SHALL cover: release reset, en=1, bus=8'hA5 during slot 0 -> 1 cycle oe=0000, then 7 cycles oe=0001; sample_stb and changed high at k=4; rd_slot=0 gives rd_data=8'hA5, rd_valid=1.
REQ-032 SHALL cover: run 32 cycles -> oe sequence 0001, 0010, 0100, 1000, each preceded by one oe=0000 cycle; slot wraps 3 -> 0 at cycle 32.
REQ-033 SHALL cover: second round with slot 0 bus still 8'hA5 -> sample_stb=1, changed=0; third round bus=8'h3C -> changed=1, rd_data=8'h3C.
REQ-034 SHALL cover: en=0 at slot 2, k=5 -> oe=0000 next cycle, slot stays 2; en=1 again -> GAP, then oe=0100 for 7 cycles.
REQ-035 SHALL cover: en=0 during SAMPLE -> no sample_stb and data unchanged; rst_n=0 mid-HOLD -> all outputs at reset values at the next edge.
